// File: rtl/gbuff_drain_pkg.sv
// Shared constants and FSM encoding for the output global-buffer drain engine.
package gbuff_drain_pkg;
  localparam int GBUFF_WORD_SIZE = 32;
  localparam int GBUFF_INDX_SIZE = 8;
  localparam int FIFO_DEPTH      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;
endpackage

// File: rtl/gbuff_drain_skid_fifo.sv
// Two-entry register FIFO with a registered head; absorbs the buffer read latency
// under downstream backpressure. Usable by any global-buffer reader.
module drain_skid_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_occ
);
  logic [W-1:0] r_head, r_tail;
  logic [1:0]   r_occ;
  logic         w_pop;

  assign w_pop   = i_pop && (r_occ != 2'd0);
  assign o_valid = (r_occ != 2'd0);
  assign o_head  = r_head;
  assign o_occ   = r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= i_din;
          else               r_tail <= i_din;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (r_occ == 2'd1) r_head <= i_din;
          else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/gbuff_drain.sv
// Reads count words from the output global buffer starting at base and streams
// them on a valid/ready port, crediting issues against skid FIFO space.
module gbuff_drain
  import gbuff_drain_pkg::*;
#(
  parameter int WORD_SIZE = GBUFF_WORD_SIZE,
  parameter int INDX_SIZE = GBUFF_INDX_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 drain_start,
  input  logic [INDX_SIZE-1:0] base,
  input  logic [INDX_SIZE:0]   count,
  output logic                 gb_wr_en,
  output logic [INDX_SIZE-1:0] gb_index,
  output logic [WORD_SIZE-1:0] gb_data_in,
  input  logic [WORD_SIZE-1:0] gb_data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 busy,
  output logic                 drain_done
);
  drain_state_e         r_state, w_state_nx;
  logic [INDX_SIZE-1:0] r_base, r_last_idx, w_idx;
  logic [INDX_SIZE:0]   r_count, r_issued;
  logic                 r_inflight;
  logic                 w_issue, w_pop, w_accept;
  logic [1:0]           w_occ;
  logic [2:0]           w_credit;

  assign gb_wr_en   = 1'b0;
  assign gb_data_in = '0;
  assign busy       = (r_state == ST_READ) || (r_state == ST_FLUSH);
  assign drain_done = (r_state == ST_DONE);

  assign w_pop    = out_valid && out_ready;
  assign w_accept = (r_state == ST_IDLE) && drain_start && (count != '0);
  // Words still owed to the FIFO after this cycle: held + returning - leaving.
  assign w_credit = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue  = (r_state == ST_READ) && (r_issued < r_count) &&
                    (w_credit < 3'(FIFO_DEPTH));
  assign w_idx    = r_base + r_issued[INDX_SIZE-1:0];
  assign gb_index = w_issue ? w_idx : r_last_idx;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (drain_start) w_state_nx = (count == '0) ? ST_DONE : ST_READ;
      ST_READ:  if (w_issue && (r_issued + (INDX_SIZE+1)'(1) == r_count)) w_state_nx = ST_FLUSH;
      ST_FLUSH: if (w_credit == 3'd0) w_state_nx = ST_DONE;
      ST_DONE:  w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_count    <= '0;
      r_issued   <= '0;
      r_last_idx <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_inflight <= w_issue;
      if (w_accept) begin
        r_base   <= base;
        r_count  <= count;
        r_issued <= '0;
      end else if (w_issue) begin
        r_issued   <= r_issued + (INDX_SIZE+1)'(1);
        r_last_idx <= w_idx;
      end
    end
  end

  drain_skid_fifo #(.W(WORD_SIZE)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_din   (gb_data_out),
    .i_pop   (w_pop),
    .o_valid (out_valid),
    .o_head  (out_data),
    .o_occ   (w_occ)
  );
endmodule
